// File: rtl/loader_pkg.sv
// ============================================================================
// loader_pkg : shared state encoding, output bundle and defaults for the loader
// Revision   : 1.0
// ============================================================================
`default_nettype none

package loader_pkg;

  localparam int LOADER_RAM_BYTES = 16;
  localparam int LOADER_ADDR_W    = 4;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_BYTE = 3'd1,
    LOAD_ADDR = 3'd2,
    LOAD_DATA = 3'd3,
    WRITE     = 3'd4,
    DONE      = 3'd5
  } loader_state_t;

  typedef struct packed {
    logic [7:0] bus_out;
    logic       bus_oe;
    logic       n_lma;
    logic       n_lmd;
    logic       n_lr;
    logic       ready;
    logic       done_load;
    logic       cpu_hold;
  } loader_out_t;

  localparam loader_out_t LOADER_OUT_IDLE = '{
    bus_out:   8'h00,
    bus_oe:    1'b0,
    n_lma:     1'b1,
    n_lmd:     1'b1,
    n_lr:      1'b1,
    ready:     1'b0,
    done_load: 1'b0,
    cpu_hold:  1'b0
  };

  // Moore decode: the output bundle a given state presents for its whole cycle.
  function automatic loader_out_t loader_outputs(input loader_state_t st,
                                                 input logic [7:0]    data_val,
                                                 input logic [7:0]    addr_val);
    loader_out_t o;
    o = LOADER_OUT_IDLE;
    case (st)
      WAIT_BYTE: begin
        o.ready    = 1'b1;
        o.cpu_hold = 1'b1;
      end
      LOAD_ADDR: begin
        o.bus_out  = addr_val;
        o.bus_oe   = 1'b1;
        o.n_lma    = 1'b0;
        o.cpu_hold = 1'b1;
      end
      LOAD_DATA: begin
        o.bus_out  = data_val;
        o.bus_oe   = 1'b1;
        o.n_lmd    = 1'b0;
        o.cpu_hold = 1'b1;
      end
      WRITE: begin
        o.n_lr     = 1'b0;
        o.cpu_hold = 1'b1;
      end
      DONE: begin
        o.done_load = 1'b1;
        o.cpu_hold  = 1'b1;
      end
      default: o = LOADER_OUT_IDLE;
    endcase
    return o;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_edge_detect.sv
// ============================================================================
// sync_edge_detect : multi-stage synchronizer with registered rising-edge pulse
// Revision         : 1.0
// ============================================================================
`default_nettype none

module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic edge_pulse
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [SYNC_STAGES-1:0] primed_q, primed_d;
  logic                   prev_q, prev_d;
  logic                   prev_valid_q, prev_valid_d;
  logic                   pulse_q, pulse_d;
  logic                   sample;
  logic                   sample_valid;

  // primed_q tracks how far real samples have propagated since reset, so a pin
  // already high at reset release is not mistaken for a fresh strobe.
  generate
    if (SYNC_STAGES == 1) begin : g_single
      always_comb begin
        sync_d   = async_in;
        primed_d = 1'b1;
      end
    end else begin : g_multi
      always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], async_in};
        primed_d = {primed_q[SYNC_STAGES-2:0], 1'b1};
      end
    end
  endgenerate

  always_comb begin
    sample       = sync_q[SYNC_STAGES-1];
    sample_valid = primed_q[SYNC_STAGES-1];
    prev_d       = sample;
    prev_valid_d = sample_valid;
    pulse_d      = sample & sample_valid & prev_valid_q & ~prev_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q       <= '0;
      primed_q     <= '0;
      prev_q       <= 1'b0;
      prev_valid_q <= 1'b0;
      pulse_q      <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      primed_q     <= primed_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      pulse_q      <= pulse_d;
    end
  end

  assign edge_pulse = pulse_q;

endmodule

`default_nettype wire

// File: rtl/program_loader.sv
// ============================================================================
// program_loader : fills RAM from host bytes through the MAR while the CPU is held
// Revision       : 1.0
// ============================================================================
`default_nettype none

module program_loader
  import loader_pkg::*;
#(
  parameter int RAM_BYTES   = LOADER_RAM_BYTES,
  parameter int ADDR_W      = LOADER_ADDR_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              programming,
  input  logic              ui_valid,
  input  logic [7:0]        ui_data,
  output logic [7:0]        bus_out,
  output logic              bus_oe,
  output logic              n_lma,
  output logic              n_lmd,
  output logic              n_lr,
  output logic              ready,
  output logic              done_load,
  output logic              cpu_hold,
  output logic [ADDR_W-1:0] load_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_BYTES - 1);

  loader_state_t     state_q, state_d;
  logic [ADDR_W-1:0] load_addr_q, load_addr_d;
  logic [7:0]        byte_q, byte_d;
  loader_out_t       out_q, out_d;
  logic              valid_edge;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_valid_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .async_in   (ui_valid),
    .edge_pulse (valid_edge)
  );

  always_comb begin
    state_d     = state_q;
    load_addr_d = load_addr_q;
    byte_d      = byte_q;

    case (state_q)
      IDLE: begin
        if (programming) begin
          state_d     = WAIT_BYTE;
          load_addr_d = '0;
        end
      end
      WAIT_BYTE: begin
        if (valid_edge) begin
          byte_d  = ui_data;
          state_d = LOAD_ADDR;
        end
      end
      LOAD_ADDR: state_d = LOAD_DATA;
      LOAD_DATA: state_d = WRITE;
      WRITE: begin
        if (load_addr_q == LAST_ADDR) begin
          state_d = DONE;
        end else begin
          load_addr_d = load_addr_q + ADDR_W'(1);
          state_d     = WAIT_BYTE;
        end
      end
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase

    // Leaving programming mode overrides everything; the current state's
    // outputs are already registered, so an in-flight strobe still completes.
    if (state_q != IDLE && !programming) begin
      state_d     = IDLE;
      load_addr_d = '0;
    end

    // Outputs are registered from the next state so they align with state_q.
    out_d = loader_outputs(state_d, byte_d, 8'(load_addr_d));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      load_addr_q <= '0;
      byte_q      <= 8'h00;
      out_q       <= LOADER_OUT_IDLE;
    end else begin
      state_q     <= state_d;
      load_addr_q <= load_addr_d;
      byte_q      <= byte_d;
      out_q       <= out_d;
    end
  end

  assign bus_out   = out_q.bus_out;
  assign bus_oe    = out_q.bus_oe;
  assign n_lma     = out_q.n_lma;
  assign n_lmd     = out_q.n_lmd;
  assign n_lr      = out_q.n_lr;
  assign ready     = out_q.ready;
  assign done_load = out_q.done_load;
  assign cpu_hold  = out_q.cpu_hold;
  assign load_addr = load_addr_q;

endmodule

`default_nettype wire
